// File: rtl/fml_bram_target.sv
// FML target backed by an on-chip 16-bit byte-writable SRAM.
// Serves 8-beat critical-word-first bursts that wrap inside a 16-byte line,
// with a programmable delay from request to acknowledge.
module fml_bram_target #(
    parameter int fml_depth   = 23,
    parameter int mem_depth   = 12,
    parameter int ack_latency = 2
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [fml_depth-1:0] fml_adr,
    input  logic                 fml_stb,
    input  logic                 fml_we,
    output logic                 fml_ack,
    input  logic [1:0]           fml_sel,
    input  logic [15:0]          fml_di,
    output logic [15:0]          fml_do
);

    localparam int         LW       = mem_depth - 3;
    localparam logic [3:0] LAT_LAST = 4'(ack_latency - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

    state_t          r_state, w_state_nxt;
    logic [3:0]      r_lat, w_lat_nxt;
    logic [2:0]      r_beat, w_beat_nxt;
    logic            r_ack, w_ack_nxt;
    logic [LW-1:0]   r_line, w_line_nxt;
    logic [2:0]      r_start, w_start_nxt;
    logic            r_we, w_we_nxt;

    logic [15:0]          r_mem [0:(1<<mem_depth)-1];
    logic [15:0]          r_rdata;
    logic [mem_depth-1:0] w_rd_addr;
    logic [mem_depth-1:0] w_wr_addr;
    logic                 w_wr_en;
    logic                 w_unused;

    // Address bits above the SRAM size alias; bit 0 is a byte offset.
    assign w_unused = ^{fml_adr[fml_depth-1:mem_depth+1], fml_adr[0]};

    // Control state register; reset aborts any burst in progress.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
            r_lat   <= 4'd0;
            r_beat  <= 3'd0;
            r_ack   <= 1'b0;
            r_line  <= '0;
            r_start <= 3'd0;
            r_we    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_lat   <= w_lat_nxt;
            r_beat  <= w_beat_nxt;
            r_ack   <= w_ack_nxt;
            r_line  <= w_line_nxt;
            r_start <= w_start_nxt;
            r_we    <= w_we_nxt;
        end
    end

    // Next-state logic: accept in IDLE, count latency in WAIT, 8 beats in BURST.
    always_comb begin
        w_state_nxt = r_state;
        w_lat_nxt   = r_lat;
        w_beat_nxt  = r_beat;
        w_ack_nxt   = 1'b0;
        w_line_nxt  = r_line;
        w_start_nxt = r_start;
        w_we_nxt    = r_we;
        case (r_state)
            S_IDLE: begin
                if (fml_stb) begin
                    w_line_nxt  = fml_adr[mem_depth:4];
                    w_start_nxt = fml_adr[3:1];
                    w_we_nxt    = fml_we;
                    w_beat_nxt  = 3'd0;
                    if (ack_latency == 1) begin
                        w_state_nxt = S_BURST;
                        w_ack_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_lat_nxt   = 4'd1;
                    end
                end
            end
            S_WAIT: begin
                w_lat_nxt = r_lat + 4'd1;
                if (r_lat == LAT_LAST) begin
                    w_state_nxt = S_BURST;
                    w_ack_nxt   = 1'b1;
                    w_lat_nxt   = 4'd0;
                end
            end
            S_BURST: begin
                w_beat_nxt = r_beat + 3'd1;
                if (r_beat == 3'd7) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Read address runs one beat ahead of the output because the SRAM read is
    // registered; in IDLE the live request address feeds the ack_latency=1 case.
    always_comb begin
        case (r_state)
            S_IDLE:  w_rd_addr = fml_adr[mem_depth:1];
            S_WAIT:  w_rd_addr = {r_line, r_start};
            default: w_rd_addr = {r_line, 3'(r_start + r_beat + 3'd1)};
        endcase
    end

    assign w_wr_addr = {r_line, 3'(r_start + r_beat)};
    assign w_wr_en   = (r_state == S_BURST) && r_we;

    // SRAM: byte-enabled write and registered read. A read beat can never
    // share a cycle with a write beat, so previously written data is visible.
    always_ff @(posedge sys_clk) begin
        if (w_wr_en) begin
            if (fml_sel[0]) r_mem[w_wr_addr][7:0]  <= fml_di[7:0];
            if (fml_sel[1]) r_mem[w_wr_addr][15:8] <= fml_di[15:8];
        end
        r_rdata <= r_mem[w_rd_addr];
    end

    assign fml_ack = r_ack;
    assign fml_do  = (r_state == S_BURST && !r_we) ? r_rdata : 16'h0000;

endmodule

// File: tb/tb_fml_bram_target.sv
// Directed bench for fml_bram_target: three instances (ack latency 2, 1, 15),
// a reference memory model, and a queue of expected read beats.
module tb_fml_bram_target;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [22:0] adr;
    logic        we;
    logic [1:0]  sel;
    logic [15:0] di;
    logic [2:0]  stb;
    logic [2:0]  ack;
    logic [15:0] dout [3];

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] model [3][4096];
    logic [15:0] exp_q [$];
    int          lat_of [3] = '{2, 1, 15};

    always #5 clk = ~clk;

    fml_bram_target #(.fml_depth(23), .mem_depth(12), .ack_latency(2)) u_l2 (
        .sys_clk(clk), .sys_rst_n(rst_n), .fml_adr(adr), .fml_stb(stb[0]),
        .fml_we(we), .fml_ack(ack[0]), .fml_sel(sel), .fml_di(di), .fml_do(dout[0]));
    fml_bram_target #(.fml_depth(23), .mem_depth(12), .ack_latency(1)) u_l1 (
        .sys_clk(clk), .sys_rst_n(rst_n), .fml_adr(adr), .fml_stb(stb[1]),
        .fml_we(we), .fml_ack(ack[1]), .fml_sel(sel), .fml_di(di), .fml_do(dout[1]));
    fml_bram_target #(.fml_depth(23), .mem_depth(12), .ack_latency(15)) u_l15 (
        .sys_clk(clk), .sys_rst_n(rst_n), .fml_adr(adr), .fml_stb(stb[2]),
        .fml_we(we), .fml_ack(ack[2]), .fml_sel(sel), .fml_di(di), .fml_do(dout[2]));

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One burst on instance d. Write data for beat k is base + incr*k.
    // abort_at >= 0 drops reset in the middle of that beat's cycle.
    task automatic burst(input int d, input logic [22:0] a, input logic w,
                         input logic [15:0] base, input logic [15:0] incr,
                         input logic [1:0] s, input bit hold, input int abort_at);
        int          n;
        logic [8:0]  line;
        logic [2:0]  st;
        logic [11:0] idx;
        logic [15:0] dv;
        logic [15:0] e;
        line = a[12:4];
        st   = a[3:1];
        if (!w) begin
            for (int k = 0; k < 8; k++) begin
                idx = {line, 3'(st + 3'(k))};
                exp_q.push_back(model[d][idx]);
            end
        end
        adr    = a;
        we     = w;
        sel    = s;
        di     = base;
        stb[d] = 1'b1;
        n = 0;
        while (ack[d] !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        if (ack[d] !== 1'b1) begin
            check($sformatf("ack_timeout_d%0d", d), 16'(ack[d]), 16'd1);
            stb[d] = 1'b0;
            exp_q.delete();
            return;
        end
        check($sformatf("ack_latency_d%0d", d), 16'(n), 16'(lat_of[d]));
        for (int k = 0; k < 8; k++) begin
            dv = base + incr * 16'(k);
            di = dv;
            if (k == 1 && !hold) stb[d] = 1'b0;
            if (k == 2 && hold)  stb[d] = 1'b0;
            if (k == abort_at) begin
                #2;
                rst_n = 1'b0;
                #1;
                check($sformatf("abort_ack_d%0d", d), 16'(ack[d]), 16'd0);
                check($sformatf("abort_do_d%0d", d), dout[d], 16'h0000);
                stb[d] = 1'b0;
                exp_q.delete();
                step();
                step();
                rst_n = 1'b1;
                step();
                return;
            end
            check($sformatf("ack_beat%0d_d%0d", k, d), 16'(ack[d]), 16'(k == 0));
            if (!w) begin
                if (exp_q.size() == 0) begin
                    check("queue_underflow", 16'd0, 16'd1);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("rd_beat%0d_d%0d", k, d), dout[d], e);
                end
            end else begin
                check($sformatf("wr_do_zero%0d_d%0d", k, d), dout[d], 16'h0000);
                idx = {line, 3'(st + 3'(k))};
                if (s[0]) model[d][idx][7:0]  = dv[7:0];
                if (s[1]) model[d][idx][15:8] = dv[15:8];
            end
            step();
        end
        check($sformatf("idle_ack_d%0d", d), 16'(ack[d]), 16'd0);
        check($sformatf("idle_do_d%0d", d), dout[d], 16'h0000);
    endtask

    initial begin
        rst_n = 1'b1;
        stb   = 3'b000;
        adr   = '0;
        we    = 1'b0;
        sel   = 2'b00;
        di    = 16'h0000;

        // Asynchronous reset asserted mid-cycle.
        #3;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_ack_d%0d", d), 16'(ack[d]), 16'd0);
            check($sformatf("reset_do_d%0d", d), dout[d], 16'h0000);
        end
        step();
        step();
        rst_n = 1'b1;
        step();

        // Linear write then aligned read.
        burst(0, 23'h000100, 1'b1, 16'h1000, 16'h0001, 2'b11, 1'b0, -1);
        burst(0, 23'h000100, 1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0, -1);
        // Wrapped read starting at word 5.
        burst(0, 23'h00010A, 1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0, -1);
        // Low-byte-only write, then high-byte-only write from word 4.
        burst(0, 23'h000100, 1'b1, 16'hAAAA, 16'h0000, 2'b01, 1'b0, -1);
        burst(0, 23'h000100, 1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0, -1);
        burst(0, 23'h000108, 1'b1, 16'h5500, 16'h0100, 2'b10, 1'b0, -1);
        burst(0, 23'h00010E, 1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0, -1);
        // Upper address bits alias onto the same line.
        burst(0, 23'h002104, 1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0, -1);

        // Extreme latencies, stb held one extra cycle after ack.
        burst(1, 23'h000200, 1'b1, 16'h2000, 16'h0101, 2'b11, 1'b1, -1);
        burst(1, 23'h000206, 1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1, -1);
        burst(2, 23'h000300, 1'b1, 16'h3000, 16'h0011, 2'b11, 1'b1, -1);
        burst(2, 23'h00030C, 1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1, -1);

        // Back-to-back write and read of the same line, no idle gap.
        burst(0, 23'h000400, 1'b1, 16'h4000, 16'h0003, 2'b11, 1'b0, -1);
        burst(0, 23'h000400, 1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0, -1);
        burst(1, 23'h000210, 1'b1, 16'h6000, 16'h0007, 2'b11, 1'b0, -1);
        burst(1, 23'h000210, 1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0, -1);

        // Reset during beat 4 of a write: only beats 0..3 land.
        burst(0, 23'h000400, 1'b1, 16'h5000, 16'h0001, 2'b11, 1'b0, 4);
        burst(0, 23'h000400, 1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0, -1);
        // Reset during a read beat clears the data output immediately.
        burst(0, 23'h000100, 1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0, 3);
        burst(0, 23'h000102, 1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0, -1);

        check("queue_empty", 16'(exp_q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
